// File: rtl/spi_ram_p_if.sv
// Command/response bundle between the SPI slave datapath and spi_ram_p.
// The master drives commands and the slave returns read data, strobe and error.
interface spi_ram_p_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_valid;
    logic [DATA_WIDTH+1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  addr_err;

    modport master (
        output rx_valid, din,
        input  dout, tx_valid, addr_err
    );

    modport slave (
        input  rx_valid, din,
        output dout, tx_valid, addr_err
    );
endinterface

// File: rtl/spi_ram_p.sv
// Single-port RAM with separate write/read pointers behind the SPI slave; one command per cycle,
// read data returned one cycle after the command with a one-cycle tx_valid strobe; no backpressure.
module spi_ram_p #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 8,
    parameter int MEM_DEPTH  = 256,
    parameter bit AUTO_INC   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    spi_ram_p_if.slave  bus
);
    typedef enum logic [1:0] {
        OP_SET_WR = 2'b00,
        OP_WRITE  = 2'b01,
        OP_SET_RD = 2'b10,
        OP_READ   = 2'b11
    } op_e;

    // One extra bit so a depth of exactly 2**ADDR_SIZE is representable.
    localparam logic [ADDR_SIZE:0]   LP_DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LP_LAST  = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0]  r_wr_ptr;
    logic [ADDR_SIZE-1:0]  r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_tx_valid;
    logic                  r_addr_err;

    op_e                   w_op;
    logic [DATA_WIDTH-1:0] w_payload;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_we;
    logic [ADDR_SIZE-1:0]  w_wr_ptr_nxt;
    logic [ADDR_SIZE-1:0]  w_rd_ptr_nxt;
    logic [DATA_WIDTH-1:0] w_dout_nxt;
    logic                  w_tx_valid_nxt;
    logic                  w_addr_err_nxt;

    // Out-of-range pointers fall into the ">= last" case and restart at 0.
    function automatic logic [ADDR_SIZE-1:0] f_next_ptr(input logic [ADDR_SIZE-1:0] p);
        return (p >= LP_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_op          = op_e'(bus.din[DATA_WIDTH+1:DATA_WIDTH]);
    assign w_payload     = bus.din[DATA_WIDTH-1:0];
    assign w_wr_in_range = ({1'b0, r_wr_ptr} < LP_DEPTH);
    assign w_rd_in_range = ({1'b0, r_rd_ptr} < LP_DEPTH);

    always_comb begin
        w_we           = 1'b0;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_dout_nxt     = r_dout;
        w_tx_valid_nxt = 1'b0;
        w_addr_err_nxt = r_addr_err;
        if (bus.rx_valid) begin
            case (w_op)
                OP_SET_WR: w_wr_ptr_nxt = w_payload[ADDR_SIZE-1:0];
                OP_WRITE: begin
                    if (w_wr_in_range) w_we = 1'b1;
                    else               w_addr_err_nxt = 1'b1;
                    if (AUTO_INC) w_wr_ptr_nxt = f_next_ptr(r_wr_ptr);
                end
                OP_SET_RD: w_rd_ptr_nxt = w_payload[ADDR_SIZE-1:0];
                OP_READ: begin
                    w_tx_valid_nxt = 1'b1;
                    if (w_rd_in_range) begin
                        w_dout_nxt = r_mem[r_rd_ptr];
                    end else begin
                        w_dout_nxt     = '0;
                        w_addr_err_nxt = 1'b1;
                    end
                    if (AUTO_INC) w_rd_ptr_nxt = f_next_ptr(r_rd_ptr);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_dout     <= '0;
            r_tx_valid <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_dout     <= w_dout_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_addr_err <= w_addr_err_nxt;
        end
    end

    // Array kept out of the reset block so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_we && !rst) r_mem[r_wr_ptr] <= w_payload;
    end

    assign bus.dout     = r_dout;
    assign bus.tx_valid = r_tx_valid;
    assign bus.addr_err = r_addr_err;
endmodule

// File: tb/tb_spi_ram_p.sv
// Directed vector bench for spi_ram_p across four parameter sets sharing one clock.
module tb_spi_ram_p;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [4];

    spi_ram_p_if #(.DATA_WIDTH(8))  if0 ();
    spi_ram_p_if #(.DATA_WIDTH(8))  if1 ();
    spi_ram_p_if #(.DATA_WIDTH(8))  if2 ();
    spi_ram_p_if #(.DATA_WIDTH(16)) if3 ();

    spi_ram_p #(.DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1'b0))
        u0 (.clk(clk), .rst(rst[0]), .bus(if0));
    spi_ram_p #(.DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1'b1))
        u1 (.clk(clk), .rst(rst[1]), .bus(if1));
    spi_ram_p #(.DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(200), .AUTO_INC(1'b1))
        u2 (.clk(clk), .rst(rst[2]), .bus(if2));
    spi_ram_p #(.DATA_WIDTH(16), .ADDR_SIZE(10), .MEM_DEPTH(1024), .AUTO_INC(1'b0))
        u3 (.clk(clk), .rst(rst[3]), .bus(if3));

    typedef struct {
        int          dut;
        logic        r;
        logic        vld;
        logic [1:0]  op;
        logic [15:0] pay;
        logic [15:0] exp_dout;
        logic        exp_tx;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic vec_t mk(int d, logic r, logic vl, logic [1:0] op, logic [15:0] p,
                                logic [15:0] ed, logic et, logic ee);
        vec_t v;
        v.dut = d; v.r = r; v.vld = vl; v.op = op; v.pay = p;
        v.exp_dout = ed; v.exp_tx = et; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input int d, input logic r, input logic vl, input logic [1:0] op,
                         input logic [15:0] p);
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        if0.rx_valid = 1'b0; if1.rx_valid = 1'b0; if2.rx_valid = 1'b0; if3.rx_valid = 1'b0;
        case (d)
            0: begin rst[0] = r; if0.rx_valid = vl; if0.din = {op, p[7:0]}; end
            1: begin rst[1] = r; if1.rx_valid = vl; if1.din = {op, p[7:0]}; end
            2: begin rst[2] = r; if2.rx_valid = vl; if2.din = {op, p[7:0]}; end
            default: begin rst[3] = r; if3.rx_valid = vl; if3.din = {op, p}; end
        endcase
    endtask

    task automatic sample(input int d, output logic [15:0] dout, output logic tx, output logic err);
        case (d)
            0: begin dout = {8'h00, if0.dout}; tx = if0.tx_valid; err = if0.addr_err; end
            1: begin dout = {8'h00, if1.dout}; tx = if1.tx_valid; err = if1.addr_err; end
            2: begin dout = {8'h00, if2.dout}; tx = if2.tx_valid; err = if2.addr_err; end
            default: begin dout = if3.dout; tx = if3.tx_valid; err = if3.addr_err; end
        endcase
    endtask

    initial begin
        logic [15:0] a_dout;
        logic        a_tx;
        logic        a_err;
        int          cnt;

        if0.din = '0; if1.din = '0; if2.din = '0; if3.din = '0;

        // Reset every instance together and check the reset state.
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0);
        for (int i = 0; i < 4; i++) rst[i] = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) begin
            sample(d, a_dout, a_tx, a_err);
            check($sformatf("rst%0d dout", d), a_dout, 16'h0);
            check($sformatf("rst%0d tx", d), {15'h0, a_tx}, 16'h0);
            check($sformatf("rst%0d err", d), {15'h0, a_err}, 16'h0);
        end

        // Basic write/read, memory retention across reset, reset beats a read.
        vq.push_back(mk(0, 0, 1, 2'b00, 16'h05, 16'h00, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b01, 16'hA5, 16'h00, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b10, 16'h05, 16'h00, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b11, 16'h00, 16'hA5, 1, 0));
        vq.push_back(mk(0, 0, 0, 2'b11, 16'h00, 16'hA5, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b00, 16'h10, 16'hA5, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b01, 16'h3C, 16'hA5, 0, 0));
        vq.push_back(mk(0, 1, 0, 2'b00, 16'h00, 16'h00, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b10, 16'h10, 16'h00, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b11, 16'h00, 16'h3C, 1, 0));
        vq.push_back(mk(0, 1, 1, 2'b11, 16'h00, 16'h00, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b10, 16'h05, 16'h00, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b11, 16'h00, 16'hA5, 1, 0));
        // Auto-increment with wrap at 0xFF, back-to-back reads, independent pointers.
        vq.push_back(mk(1, 0, 1, 2'b00, 16'hFE, 16'h00, 0, 0));
        vq.push_back(mk(1, 0, 1, 2'b01, 16'h11, 16'h00, 0, 0));
        vq.push_back(mk(1, 0, 1, 2'b01, 16'h22, 16'h00, 0, 0));
        vq.push_back(mk(1, 0, 1, 2'b01, 16'h33, 16'h00, 0, 0));
        vq.push_back(mk(1, 0, 1, 2'b10, 16'hFE, 16'h00, 0, 0));
        vq.push_back(mk(1, 0, 1, 2'b11, 16'h00, 16'h11, 1, 0));
        vq.push_back(mk(1, 0, 1, 2'b11, 16'h00, 16'h22, 1, 0));
        vq.push_back(mk(1, 0, 1, 2'b11, 16'h00, 16'h33, 1, 0));
        vq.push_back(mk(1, 0, 1, 2'b01, 16'h44, 16'h33, 0, 0));
        vq.push_back(mk(1, 0, 1, 2'b11, 16'h00, 16'h44, 1, 0));
        // Depth 200: out-of-range write/read, sticky error, wrap at 199.
        vq.push_back(mk(2, 0, 1, 2'b00, 16'hC8, 16'h00, 0, 0));
        vq.push_back(mk(2, 0, 1, 2'b01, 16'h77, 16'h00, 0, 1));
        vq.push_back(mk(2, 0, 1, 2'b10, 16'hC8, 16'h00, 0, 1));
        vq.push_back(mk(2, 0, 1, 2'b11, 16'h00, 16'h00, 1, 1));
        vq.push_back(mk(2, 0, 1, 2'b01, 16'h55, 16'h00, 0, 1));
        vq.push_back(mk(2, 0, 1, 2'b11, 16'h00, 16'h55, 1, 1));
        vq.push_back(mk(2, 0, 1, 2'b00, 16'hC7, 16'h55, 0, 1));
        vq.push_back(mk(2, 0, 1, 2'b01, 16'h99, 16'h55, 0, 1));
        vq.push_back(mk(2, 0, 1, 2'b01, 16'h66, 16'h55, 0, 1));
        vq.push_back(mk(2, 0, 1, 2'b10, 16'hC7, 16'h55, 0, 1));
        vq.push_back(mk(2, 0, 1, 2'b11, 16'h00, 16'h99, 1, 1));
        vq.push_back(mk(2, 0, 1, 2'b11, 16'h00, 16'h66, 1, 1));
        vq.push_back(mk(2, 0, 1, 2'b10, 16'hC9, 16'h66, 0, 1));
        vq.push_back(mk(2, 0, 1, 2'b11, 16'h00, 16'h00, 1, 1));
        vq.push_back(mk(2, 1, 0, 2'b00, 16'h00, 16'h00, 0, 0));
        vq.push_back(mk(2, 0, 0, 2'b00, 16'h00, 16'h00, 0, 0));
        // 16-bit data, 10-bit pointers, top address and ignored upper payload bits.
        vq.push_back(mk(3, 0, 1, 2'b00, 16'h03FF, 16'h0000, 0, 0));
        vq.push_back(mk(3, 0, 1, 2'b01, 16'hBEEF, 16'h0000, 0, 0));
        vq.push_back(mk(3, 0, 1, 2'b10, 16'h03FF, 16'h0000, 0, 0));
        vq.push_back(mk(3, 0, 1, 2'b11, 16'h0000, 16'hBEEF, 1, 0));
        vq.push_back(mk(3, 0, 0, 2'b11, 16'h0000, 16'hBEEF, 0, 0));
        vq.push_back(mk(3, 0, 0, 2'b01, 16'h0000, 16'hBEEF, 0, 0));
        vq.push_back(mk(3, 0, 1, 2'b00, 16'hFC05, 16'hBEEF, 0, 0));
        vq.push_back(mk(3, 0, 1, 2'b01, 16'h1234, 16'hBEEF, 0, 0));
        vq.push_back(mk(3, 0, 1, 2'b10, 16'h0005, 16'hBEEF, 0, 0));
        vq.push_back(mk(3, 0, 1, 2'b11, 16'h0000, 16'h1234, 1, 0));

        foreach (vq[i]) begin
            drive(vq[i].dut, vq[i].r, vq[i].vld, vq[i].op, vq[i].pay);
            @(posedge clk); #1;
            sample(vq[i].dut, a_dout, a_tx, a_err);
            check($sformatf("v%0d dout", i), a_dout, vq[i].exp_dout);
            check($sformatf("v%0d tx", i), {15'h0, a_tx}, {15'h0, vq[i].exp_tx});
            check($sformatf("v%0d err", i), {15'h0, a_err}, {15'h0, vq[i].exp_err});
        end

        // A single read must give exactly one tx_valid cycle.
        cnt = 0;
        drive(0, 1'b0, 1'b1, 2'b11, 16'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (if0.tx_valid) cnt++;
            drive(0, 1'b0, 1'b0, 2'b00, 16'h0);
        end
        check("tx_pulse_len", 16'(cnt), 16'd1);
        check("tx_pulse_dout", {8'h00, if0.dout}, 16'h00A5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/spi_ram_p.md
Name: spi_ram_p

Overview:
Parametrised single-port RAM behind the SPI slave. It consumes command words {opcode[1:0], payload} from the SPI receive path. It keeps separate write and read address pointers, optionally auto-incrementing, and returns read data with a one-cycle tx_valid strobe to the SPI transmit path. It generalises the fixed 256x8 RAM with address range checking, pointer wrap-around and a sticky error flag.

Parameters:
DATA_WIDTH, 8, memory word width and payload width.
ADDR_SIZE, 8, pointer width; must be <= DATA_WIDTH.
MEM_DEPTH, 256, number of words; must be <= 2**ADDR_SIZE; need not be a power of two.
AUTO_INC, 0, 1 = post-increment the pointer after each data write or data read.

Ports:
clk  input  1  single clock; everything updates on the rising edge.
rst  input  1  synchronous, active-high reset.
rx_valid  input  1  din carries a command this cycle.
din  input  DATA_WIDTH+2  [DATA_WIDTH+1:DATA_WIDTH] = opcode, [DATA_WIDTH-1:0] = payload.
dout  output  DATA_WIDTH  read data; registered; holds its value between reads.
tx_valid  output  1  one-cycle strobe; dout is valid when it is high.
addr_err  output  1  sticky out-of-range access flag.

Behaviour:
- Reset (rst=1 at an edge): dout=0, tx_valid=0, addr_err=0, wr_ptr=0, rd_ptr=0. Memory contents are not cleared and keep their values across reset. Reset has priority over rx_valid.
- A command is accepted only on an edge with rx_valid=1. rx_valid=0 means no state change except tx_valid <= 0.
- Opcode 00 (set write address): wr_ptr <= payload[ADDR_SIZE-1:0]. Upper payload bits are ignored.
- Opcode 01 (write data):
  - If wr_ptr < MEM_DEPTH: mem[wr_ptr] <= payload.
  - Otherwise: no write, and addr_err <= 1.
  - With AUTO_INC=1, wr_ptr then advances: wr_ptr <= (wr_ptr == MEM_DEPTH-1) ? 0 : wr_ptr+1. An out-of-range wr_ptr also goes to 0.
- Opcode 10 (set read address): rd_ptr <= payload[ADDR_SIZE-1:0].
- Opcode 11 (read data):
  - On the accepting edge, dout <= mem[rd_ptr] and tx_valid <= 1. Latency is 1 cycle: dout and tx_valid are visible in the cycle after the command.
  - If rd_ptr >= MEM_DEPTH: dout <= 0, tx_valid <= 1, addr_err <= 1.
  - With AUTO_INC=1, rd_ptr advances using the same wrap rule as wr_ptr.
  - Only opcode 11 sets tx_valid.
- tx_valid is high for exactly one cycle per read command. Reads on consecutive cycles give tx_valid held high, with dout updating every cycle.
- Read-after-write: a read on the cycle after a write to the same address returns the new data. There is no forwarding hazard because only one command is accepted per cycle.
- wr_ptr and rd_ptr are independent. A pointer changes only through its own set-address opcode or through auto-increment.
- addr_err clears only on rst.
- Internal state: the two pointers and the output registers. The opcode decode acts as a one-cycle command FSM with no multi-cycle states, so back-to-back commands are legal every cycle.

Test Plan:
1. Reset, then rx_valid with {00,0x05}, {01,0xA5}, {10,0x05}, {11,xx} -> one cycle after the read, dout=0xA5 and tx_valid=1 for exactly 1 cycle; addr_err=0.
2. AUTO_INC=1, MEM_DEPTH=256: {00,0xFE}, write 0x11, 0x22, 0x33; then {10,0xFE} and 3 back-to-back reads -> dout sequence 0x11, 0x22, 0x33 at addresses 0xFE, 0xFF, 0x00; tx_valid high for 3 consecutive cycles.
3. MEM_DEPTH=200: {00,0xC8} then {01,0x77} -> no memory change; addr_err=1. {10,0xC8}, {11} -> dout=0, tx_valid=1. addr_err stays 1 until rst.
4. Write 0x3C to address 0x10, assert rst for 1 cycle, then {10,0x10}, {11} -> dout=0x3C, proving memory is retained. Outputs are 0 directly after reset.
5. Assert rst in the same cycle as a {11} command -> tx_valid stays 0 and dout=0.
6. DATA_WIDTH=16, ADDR_SIZE=10, MEM_DEPTH=1024: write 0xBEEF to 0x3FF, read it back -> dout=0xBEEF; rx_valid=0 idle cycles cause no change.
